// File: rtl/space_draw_pkg.sv
// Shared definitions for the sprite draw engine: object codes, sprite sizes,
// colours, screen geometry, state encoding.
package space_draw_pkg;

    localparam logic [3:0] OBJ_NONE   = 4'd0;
    localparam logic [3:0] OBJ_PLAYER = 4'd1;
    localparam logic [3:0] OBJ_ENEMY1 = 4'd2;
    localparam logic [3:0] OBJ_ENEMY4 = 4'd5;
    localparam logic [3:0] OBJ_BULLET = 4'd6;

    localparam logic [7:0] PLAYER_W = 8'd8;
    localparam logic [6:0] PLAYER_H = 7'd8;
    localparam logic [7:0] ENEMY_W  = 8'd8;
    localparam logic [6:0] ENEMY_H  = 7'd8;
    localparam logic [7:0] BULLET_W = 8'd2;
    localparam logic [6:0] BULLET_H = 7'd4;

    localparam logic [2:0] COL_PLAYER = 3'b010;
    localparam logic [2:0] COL_ENEMY  = 3'b100;
    localparam logic [2:0] COL_BULLET = 3'b111;
    localparam logic [2:0] COL_ERASE  = 3'b000;

    localparam logic [8:0] SCREEN_W = 9'd160;
    localparam logic [7:0] SCREEN_H = 8'd120;
    localparam logic [7:0] LAST_X   = 8'd159;
    localparam logic [6:0] LAST_Y   = 7'd119;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        DRAW,
        DRAW_DONE,
        ERASE,
        ERASE_DONE
    } drawStateT;

    function automatic logic isEnemy(input logic [3:0] code);
        return (code >= OBJ_ENEMY1) && (code <= OBJ_ENEMY4);
    endfunction

    function automatic logic [7:0] spriteWidth(input logic [3:0] code);
        if (code == OBJ_PLAYER)  return PLAYER_W;
        if (isEnemy(code))       return ENEMY_W;
        if (code == OBJ_BULLET)  return BULLET_W;
        return 8'd0;
    endfunction

    function automatic logic [6:0] spriteHeight(input logic [3:0] code);
        if (code == OBJ_PLAYER)  return PLAYER_H;
        if (isEnemy(code))       return ENEMY_H;
        if (code == OBJ_BULLET)  return BULLET_H;
        return 7'd0;
    endfunction

    function automatic logic [2:0] spriteColour(input logic [3:0] code);
        if (code == OBJ_PLAYER)  return COL_PLAYER;
        if (isEnemy(code))       return COL_ENEMY;
        if (code == OBJ_BULLET)  return COL_BULLET;
        return COL_ERASE;
    endfunction

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Sequencer/VGA signal bundle for the sprite draw engine.
// master = draw sequencer side, slave = engine side.
interface sprite_draw_engine_if;
    logic [3:0] object_to_draw;
    logic       vga_plot;
    logic       in_erase_state;
    logic [7:0] obj_x;
    logic [6:0] obj_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_write;
    logic       done_drawing;
    logic       done_erasing;

    modport master (
        output object_to_draw, vga_plot, in_erase_state, obj_x, obj_y,
        input  vga_x, vga_y, vga_colour, vga_write, done_drawing, done_erasing
    );

    modport slave (
        input  object_to_draw, vga_plot, in_erase_state, obj_x, obj_y,
        output vga_x, vga_y, vga_colour, vga_write, done_drawing, done_erasing
    );
endinterface

// File: rtl/sprite_rom.sv
// 8x8 one-bit bitmaps for the player and enemy sprites (bit dx of row dy, 1 = opaque).
// Only instantiated when SPRITE_DRAW_ROM_EN is defined.
module sprite_rom
    import space_draw_pkg::*;
(
    input  logic [3:0] objCode,
    input  logic [2:0] dy,
    input  logic [2:0] dx,
    output logic       pixel
);
    logic [7:0] row;

    always_comb begin
        row = 8'hFF;
        if (objCode == OBJ_PLAYER) begin
            case (dy)
                3'd0: row = 8'b00011000;
                3'd1: row = 8'b00111100;
                3'd2: row = 8'b01111110;
                3'd3: row = 8'b11111111;
                3'd4: row = 8'b11111111;
                3'd5: row = 8'b01100110;
                3'd6: row = 8'b11000011;
                default: row = 8'b10000001;
            endcase
        end else begin
            case (dy)
                3'd0: row = 8'b10000001;
                3'd1: row = 8'b01011010;
                3'd2: row = 8'b00111100;
                3'd3: row = 8'b11111111;
                3'd4: row = 8'b10111101;
                3'd5: row = 8'b00111100;
                3'd6: row = 8'b01000010;
                default: row = 8'b10000001;
            endcase
        end
        pixel = row[dx];
    end
endmodule

// File: rtl/sprite_draw_engine.sv
// Rasterises one sprite, or erases the whole 160x120 screen, one pixel per clock.
// Define SPRITE_DRAW_ROM_EN to take player/enemy pixels from sprite_rom bitmaps instead of solid blocks.
// IDLE wait for start | LATCH capture object, emit pixel 0 | DRAW emit remaining pixels
// DRAW_DONE wait for code 0 | ERASE clear screen | ERASE_DONE wait for erase request to drop
module sprite_draw_engine
    import space_draw_pkg::*;
(
    input  logic clk,
    input  logic reset,
    sprite_draw_engine_if.slave bus
);
    drawStateT  state;
    logic [3:0] objCode;
    logic [7:0] objX;
    logic [6:0] objY;
    logic [7:0] dx;
    logic [6:0] dy;

    logic [7:0] vgaX;
    logic [6:0] vgaY;
    logic [2:0] vgaColour;
    logic       vgaWrite;
    logic       doneDrawing;
    logic       doneErasing;

    logic [3:0] curCode;
    logic [7:0] curX;
    logic [6:0] curY;
    logic [7:0] sprW;
    logic [6:0] sprH;
    logic [7:0] nextDx;
    logic [6:0] nextDy;
    logic       lastPixel;
    logic [8:0] pixX;
    logic [7:0] pixY;
    logic       onScreen;
    logic       pixelOn;

    // In LATCH the object is not yet captured, so pixel 0 is built straight from the inputs.
    always_comb begin
        curCode   = (state == LATCH) ? bus.object_to_draw : objCode;
        curX      = (state == LATCH) ? bus.obj_x : objX;
        curY      = (state == LATCH) ? bus.obj_y : objY;
        sprW      = spriteWidth(curCode);
        sprH      = spriteHeight(curCode);
        lastPixel = (dx == sprW - 8'd1) && (dy == sprH - 7'd1);
        if (state == LATCH) begin
            nextDx = 8'd0;
            nextDy = 7'd0;
        end else if (dx == sprW - 8'd1) begin
            nextDx = 8'd0;
            nextDy = dy + 7'd1;
        end else begin
            nextDx = dx + 8'd1;
            nextDy = dy;
        end
        pixX     = {1'b0, curX} + {1'b0, nextDx};
        pixY     = {1'b0, curY} + {1'b0, nextDy};
        onScreen = (pixX < SCREEN_W) && (pixY < SCREEN_H);
    end

`ifdef SPRITE_DRAW_ROM_EN
    logic romBit;

    sprite_rom uRom (
        .objCode (curCode),
        .dy      (nextDy[2:0]),
        .dx      (nextDx[2:0]),
        .pixel   (romBit)
    );

    assign pixelOn = (curCode == OBJ_BULLET) ? 1'b1 : romBit;
`else
    assign pixelOn = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            objCode     <= OBJ_NONE;
            objX        <= 8'd0;
            objY        <= 7'd0;
            dx          <= 8'd0;
            dy          <= 7'd0;
            vgaX        <= 8'd0;
            vgaY        <= 7'd0;
            vgaColour   <= 3'd0;
            vgaWrite    <= 1'b0;
            doneDrawing <= 1'b0;
            doneErasing <= 1'b0;
        end else begin
            vgaWrite    <= 1'b0;
            doneDrawing <= 1'b0;
            doneErasing <= 1'b0;
            case (state)
                IDLE: begin
                    dx <= 8'd0;
                    dy <= 7'd0;
                    if (bus.vga_plot && bus.in_erase_state) begin
                        state <= ERASE;
                    end else if (bus.vga_plot && (bus.object_to_draw != OBJ_NONE)) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    objCode <= bus.object_to_draw;
                    objX    <= bus.obj_x;
                    objY    <= bus.obj_y;
                    dx      <= 8'd0;
                    dy      <= 7'd0;
                    if ((sprW == 8'd0) || (sprH == 7'd0)) begin
                        state       <= DRAW_DONE;
                        doneDrawing <= 1'b1;
                    end else begin
                        state     <= DRAW;
                        vgaX      <= pixX[7:0];
                        vgaY      <= pixY[6:0];
                        vgaColour <= spriteColour(curCode);
                        vgaWrite  <= onScreen && pixelOn;
                    end
                end
                DRAW: begin
                    if (lastPixel) begin
                        state       <= DRAW_DONE;
                        doneDrawing <= 1'b1;
                    end else begin
                        dx        <= nextDx;
                        dy        <= nextDy;
                        vgaX      <= pixX[7:0];
                        vgaY      <= pixY[6:0];
                        vgaColour <= spriteColour(curCode);
                        vgaWrite  <= onScreen && pixelOn;
                    end
                end
                DRAW_DONE: begin
                    if (bus.object_to_draw == OBJ_NONE) state <= IDLE;
                end
                ERASE: begin
                    // The bottom-right pixel on the outputs marks the end of the sweep.
                    if (vgaWrite && (vgaX == LAST_X) && (vgaY == LAST_Y)) begin
                        state       <= ERASE_DONE;
                        doneErasing <= 1'b1;
                    end else begin
                        vgaX      <= dx;
                        vgaY      <= dy;
                        vgaColour <= COL_ERASE;
                        vgaWrite  <= 1'b1;
                        if (dx == LAST_X) begin
                            dx <= 8'd0;
                            dy <= dy + 7'd1;
                        end else begin
                            dx <= dx + 8'd1;
                        end
                    end
                end
                ERASE_DONE: begin
                    if (!bus.in_erase_state) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vga_x        = vgaX;
    assign bus.vga_y        = vgaY;
    assign bus.vga_colour   = vgaColour;
    assign bus.vga_write    = vgaWrite;
    assign bus.done_drawing = doneDrawing;
    assign bus.done_erasing = doneErasing;

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed self-checking bench for sprite_draw_engine; cycle 0 is the cycle a start is driven.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sprite_draw_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    sprite_draw_engine_if bus ();

    sprite_draw_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mask: ignore vga_write (bitmap-dependent) but still check position/colour/pulses.
    task automatic checkOut(input string tag, input logic mask, input logic expW,
                            input int expX, input int expY, input logic [2:0] expC,
                            input logic expDD, input logic expDE);
        logic [7:0] ex;
        logic [6:0] ey;
        ex = 8'(expX);
        ey = 7'(expY);
        if (mask)
            check(tag, {12'd0, bus.vga_x, bus.vga_y, bus.vga_colour, bus.done_drawing, bus.done_erasing},
                       {12'd0, ex, ey, expC, expDD, expDE});
        else if (expW)
            check(tag, {11'd0, bus.vga_write, bus.vga_x, bus.vga_y, bus.vga_colour, bus.done_drawing, bus.done_erasing},
                       {11'd0, 1'b1, ex, ey, expC, expDD, expDE});
        else
            check(tag, {29'd0, bus.vga_write, bus.done_drawing, bus.done_erasing},
                       {29'd0, 1'b0, expDD, expDE});
    endtask

    task automatic quiet(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            step();
            checkOut($sformatf("%s q%0d", tag, c), 1'b0, 1'b0, 0, 0, 3'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic release_obj();
        bus.object_to_draw = 4'd0;
        bus.vga_plot = 1'b0;
        step();
        step();
    endtask

    // Start drawn in cycle 0 and held; pixels in 2..1+W*H, done in 2+W*H, then silence.
    task automatic drawAndCheck(input string tag, input int code, input int ox, input int oy,
                                input int w, input int h, input logic [2:0] col);
        int idx, px, py;
        logic expW, mask;
        bus.object_to_draw = 4'(code);
        bus.obj_x = 8'(ox);
        bus.obj_y = 7'(oy);
        bus.in_erase_state = 1'b0;
        bus.vga_plot = 1'b1;
        for (int c = 1; c <= w * h + 12; c++) begin
            step();
            idx = c - 2;
            mask = 1'b0;
            expW = 1'b0;
            px = 0;
            py = 0;
            if (idx >= 0 && idx < w * h) begin
                px = ox + idx % w;
                py = oy + idx / w;
                expW = (px < 160) && (py < 120);
`ifdef SPRITE_DRAW_ROM_EN
                if (code >= 1 && code <= 5) begin
                    if (code == 1 && idx / w == 0) expW = (idx % w == 3) || (idx % w == 4);
                    else mask = 1'b1;
                end
`endif
            end
            checkOut($sformatf("%s c%0d", tag, c), mask, expW, px, py, col, c == w * h + 2, 1'b0);
        end
    endtask

    initial begin
        int idx;
        bus.object_to_draw = 4'd0;
        bus.vga_plot = 1'b0;
        bus.in_erase_state = 1'b0;
        bus.obj_x = 8'd0;
        bus.obj_y = 7'd0;

        step();
        step();
        check("reset outputs", {12'd0, bus.vga_write, bus.vga_x, bus.vga_y, bus.vga_colour,
                                bus.done_drawing, bus.done_erasing}, 32'd0);
        reset = 1'b0;
        quiet("post reset idle", 3);

        drawAndCheck("player", 1, 10, 20, 8, 8, 3'b010);
        release_obj();

        drawAndCheck("bullet corner", 6, 158, 118, 2, 4, 3'b111);
        release_obj();

        // Erase and a draw request together: erase wins.
        bus.object_to_draw = 4'd2;
        bus.obj_x = 8'd10;
        bus.obj_y = 7'd10;
        bus.in_erase_state = 1'b1;
        bus.vga_plot = 1'b1;
        for (int c = 1; c <= 19208; c++) begin
            step();
            idx = c - 2;
            if (idx >= 0 && idx < 19200)
                checkOut($sformatf("erase c%0d", c), 1'b0, 1'b1, idx % 160, idx / 160, 3'd0, 1'b0, 1'b0);
            else
                checkOut($sformatf("erase c%0d", c), 1'b0, 1'b0, 0, 0, 3'd0, 1'b0, c == 19202);
        end
        bus.in_erase_state = 1'b0;
        bus.vga_plot = 1'b0;
        bus.object_to_draw = 4'd0;
        quiet("erase release", 4);

        drawAndCheck("unknown code", 9, 20, 20, 0, 0, 3'd0);
        release_obj();

        // Enemy interrupted by reset while pixel 30 is on the outputs.
        bus.object_to_draw = 4'd3;
        bus.obj_x = 8'd50;
        bus.obj_y = 7'd30;
        bus.vga_plot = 1'b1;
        for (int c = 1; c <= 32; c++) step();
`ifdef SPRITE_DRAW_ROM_EN
        checkOut("enemy pixel 30", 1'b1, 1'b1, 56, 33, 3'b100, 1'b0, 1'b0);
`else
        checkOut("enemy pixel 30", 1'b0, 1'b1, 56, 33, 3'b100, 1'b0, 1'b0);
`endif
        reset = 1'b1;
        bus.object_to_draw = 4'd0;
        bus.vga_plot = 1'b0;
        step();
        check("reset mid draw", {12'd0, bus.vga_write, bus.vga_x, bus.vga_y, bus.vga_colour,
                                 bus.done_drawing, bus.done_erasing}, 32'd0);
        reset = 1'b0;
        quiet("after mid reset", 40);

        drawAndCheck("enemy redraw", 3, 50, 30, 8, 8, 3'b100);
        release_obj();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
